// File: rtl/csoc_cmd_pkg.sv
// Shared definitions for the CSoC UART command sequencer: FSM states, command opcodes, ack codes.
// Imported by csoc_cmd_ctrl and csoc_clk_gen.
package csoc_cmd_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ARG_HI,
    ST_ARG_LO,
    ST_ARG_MODE,
    ST_RUN_HI,
    ST_RUN_LO,
    ST_RST,
    ST_ACK,
    ST_ACK_WAIT
  } state_t;

  localparam logic [7:0] CMD_EXEC = 8'h65;  // 'e'
  localparam logic [7:0] CMD_RST  = 8'h72;  // 'r'
  localparam logic [7:0] CMD_TEST = 8'h74;  // 't'

  localparam logic [7:0] ACK_OK   = 8'h6B;  // 'k'
  localparam logic [7:0] ACK_UNK  = 8'h3F;  // '?'
  localparam logic [7:0] ACK_TMO  = 8'h21;  // '!'

  // States in which an incoming rx byte is consumed rather than flagged as overrun.
  function automatic logic accepts_byte(input state_t s);
    return (s == ST_IDLE) || (s == ST_ARG_HI) || (s == ST_ARG_LO) || (s == ST_ARG_MODE);
  endfunction

endpackage

// File: rtl/csoc_clk_gen.sv
// Gated CSoC clock: N pulses of CLK_DIV clks high + CLK_DIV clks low, first high phase on the clk after start.
// No backpressure; toggle/done are combinational strobes aligned with the edge that changes csoc_clk.
module csoc_clk_gen
  import csoc_cmd_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [15:0] n,
  output logic        csoc_clk,
  output logic        toggle,
  output logic        done
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_RELOAD = DW'(CLK_DIV - 1);

  logic          running;
  logic [DW-1:0] div_cnt;
  logic [15:0]   pulse_cnt;

  assign toggle = running && (div_cnt == '0);
  // The last low phase ends here; the controller leaves RUN_LO on this edge.
  assign done   = toggle && !csoc_clk && (pulse_cnt == 16'd1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      running   <= 1'b0;
      csoc_clk  <= 1'b0;
      div_cnt   <= '0;
      pulse_cnt <= '0;
    end else if (start) begin
      running   <= (n != 16'd0);
      csoc_clk  <= (n != 16'd0);
      div_cnt   <= DIV_RELOAD;
      pulse_cnt <= n;
    end else if (toggle) begin
      div_cnt <= DIV_RELOAD;
      if (csoc_clk) begin
        csoc_clk <= 1'b0;
      end else if (pulse_cnt == 16'd1) begin
        running   <= 1'b0;
        pulse_cnt <= '0;
      end else begin
        csoc_clk  <= 1'b1;
        pulse_cnt <= pulse_cnt - 16'd1;
      end
    end else if (running) begin
      div_cnt <= div_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/csoc_cmd_ctrl.sv
// UART byte-command sequencer driving CSoC clock/reset/test pins; one status byte per command via tx_start/tx_ready.
// Optional CSOC_CMD_TIMEOUT_EN aborts argument collection with '!' after TIMEOUT_CYCLES idle clks.
module csoc_cmd_ctrl
  import csoc_cmd_pkg::*;
#(
  parameter int CLK_DIV        = 4,
  parameter int RST_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       tx_ready,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       csoc_clk,
  output logic       csoc_rstn,
  output logic       csoc_test_se,
  output logic       csoc_test_tm,
  output logic       busy,
  output logic       overrun
);

  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  state_t        state, state_nxt;
  logic [7:0]    n_hi, n_hi_nxt;
  logic [7:0]    ack_code, ack_nxt;
  logic [RW-1:0] rst_cnt, rst_cnt_nxt;
  logic          tx_start_nxt;
  logic [7:0]    tx_data_nxt;
  logic          rstn_nxt, se_nxt, tm_nxt, overrun_nxt;

  logic          gen_start, gen_toggle, gen_done;

`ifdef CSOC_CMD_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] tmo_cnt, tmo_cnt_nxt;
`endif

  csoc_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk      (clk),
    .rstn     (rstn),
    .start    (gen_start),
    .n        ({n_hi, rx_data}),
    .csoc_clk (csoc_clk),
    .toggle   (gen_toggle),
    .done     (gen_done)
  );

  assign busy = (state != ST_IDLE);

  always_comb begin
    state_nxt    = state;
    n_hi_nxt     = n_hi;
    ack_nxt      = ack_code;
    rst_cnt_nxt  = rst_cnt;
    tx_start_nxt = tx_start;
    tx_data_nxt  = tx_data;
    rstn_nxt     = csoc_rstn;
    se_nxt       = csoc_test_se;
    tm_nxt       = csoc_test_tm;
    overrun_nxt  = overrun | (rx_valid & ~accepts_byte(state));
    gen_start    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            CMD_EXEC: state_nxt = ST_ARG_HI;
            CMD_TEST: state_nxt = ST_ARG_MODE;
            CMD_RST: begin
              rstn_nxt    = 1'b0;
              rst_cnt_nxt = RW'(RST_CYCLES - 1);
              state_nxt   = ST_RST;
            end
            default: begin
              ack_nxt   = ACK_UNK;
              state_nxt = ST_ACK;
            end
          endcase
        end
      end
      ST_ARG_HI: begin
        if (rx_valid) begin
          n_hi_nxt  = rx_data;
          state_nxt = ST_ARG_LO;
        end
      end
      ST_ARG_LO: begin
        if (rx_valid) begin
          rstn_nxt = 1'b1;
          if ({n_hi, rx_data} == 16'd0) begin
            ack_nxt   = ACK_OK;
            state_nxt = ST_ACK;
          end else begin
            gen_start = 1'b1;
            state_nxt = ST_RUN_HI;
          end
        end
      end
      ST_ARG_MODE: begin
        if (rx_valid) begin
          tm_nxt    = rx_data[0];
          se_nxt    = rx_data[1];
          ack_nxt   = ACK_OK;
          state_nxt = ST_ACK;
        end
      end
      // RUN states track the generator phase so csoc_clk is high only in RUN_HI.
      ST_RUN_HI: begin
        if (gen_toggle) state_nxt = ST_RUN_LO;
      end
      ST_RUN_LO: begin
        if (gen_done) begin
          ack_nxt   = ACK_OK;
          state_nxt = ST_ACK;
        end else if (gen_toggle) begin
          state_nxt = ST_RUN_HI;
        end
      end
      ST_RST: begin
        if (rst_cnt == '0) begin
          rstn_nxt  = 1'b1;
          ack_nxt   = ACK_OK;
          state_nxt = ST_ACK;
        end else begin
          rst_cnt_nxt = rst_cnt - 1'b1;
        end
      end
      ST_ACK: begin
        if (!tx_start) begin
          if (tx_ready) begin
            tx_start_nxt = 1'b1;
            tx_data_nxt  = ack_code;
          end
        end else if (!tx_ready) begin
          tx_start_nxt = 1'b0;
          state_nxt    = ST_ACK_WAIT;
        end
      end
      ST_ACK_WAIT: begin
        if (tx_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

`ifdef CSOC_CMD_TIMEOUT_EN
    tmo_cnt_nxt = '0;
    if ((state == ST_ARG_HI || state == ST_ARG_LO || state == ST_ARG_MODE) && !rx_valid) begin
      if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        ack_nxt   = ACK_TMO;
        state_nxt = ST_ACK;
      end else begin
        tmo_cnt_nxt = tmo_cnt + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= ST_IDLE;
      n_hi         <= '0;
      ack_code     <= '0;
      rst_cnt      <= '0;
      tx_start     <= 1'b0;
      tx_data      <= '0;
      csoc_rstn    <= 1'b0;
      csoc_test_se <= 1'b0;
      csoc_test_tm <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state        <= state_nxt;
      n_hi         <= n_hi_nxt;
      ack_code     <= ack_nxt;
      rst_cnt      <= rst_cnt_nxt;
      tx_start     <= tx_start_nxt;
      tx_data      <= tx_data_nxt;
      csoc_rstn    <= rstn_nxt;
      csoc_test_se <= se_nxt;
      csoc_test_tm <= tm_nxt;
      overrun      <= overrun_nxt;
    end
  end

`ifdef CSOC_CMD_TIMEOUT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) tmo_cnt <= '0;
    else       tmo_cnt <= tmo_cnt_nxt;
  end
`endif

endmodule

// File: tb/tb_csoc_cmd_ctrl.sv
// Bench for csoc_cmd_ctrl: UART tx model with ack scoreboard, csoc_clk/csoc_rstn monitors, scenario tasks.
module tb_csoc_cmd_ctrl;

  localparam int CLK_DIV        = 4;
  localparam int RST_CYCLES     = 16;
  localparam int TIMEOUT_CYCLES = 300;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_ready = 1'b1;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       csoc_clk, csoc_rstn, csoc_test_se, csoc_test_tm, busy, overrun;

  csoc_cmd_ctrl #(
    .CLK_DIV        (CLK_DIV),
    .RST_CYCLES     (RST_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .tx_ready     (tx_ready),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .csoc_clk     (csoc_clk),
    .csoc_rstn    (csoc_rstn),
    .csoc_test_se (csoc_test_se),
    .csoc_test_tm (csoc_test_tm),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] sb_exp;

  int   cyc = 0, edge_cnt = 0, gap_err = 0, last_rise = 0, clk_idle_err = 0;
  int   rst_low = 0, last_low = 0, tx_start_cnt = 0, tx_busy = 0;
  bit   tx_hold = 1'b0;
  logic prev_csoc_clk = 1'b0, prev_tx_start = 1'b0;

  // Pin monitor: rising edges of csoc_clk, their spacing, and csoc_rstn low-run length.
  always @(negedge clk) begin
    cyc++;
    if (csoc_clk && !prev_csoc_clk) begin
      if (edge_cnt > 0 && (cyc - last_rise) != 2 * CLK_DIV) gap_err++;
      last_rise = cyc;
      edge_cnt++;
    end
    if (csoc_clk && !busy) clk_idle_err++;
    prev_csoc_clk = csoc_clk;
    if (!csoc_rstn) rst_low++;
    else if (rst_low > 0) begin
      last_low = rst_low;
      rst_low  = 0;
    end
    if (tx_start && !prev_tx_start) tx_start_cnt++;
    prev_tx_start = tx_start;
  end

  // uart_tx model: accepts a byte when idle, stays busy a few clks; scoreboard checks each ack.
  always @(negedge clk) begin
    if (tx_hold) begin
      tx_ready = 1'b0;
    end else if (tx_busy > 0) begin
      tx_busy--;
      if (tx_busy == 0) tx_ready = 1'b1;
    end else if (tx_ready && tx_start) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_unexpected_ack: got 0x%02h, required no ack", tx_data);
      end else begin
        sb_exp = exp_q.pop_front();
        if (tx_data !== sb_exp) begin
          n_fail++;
          $display("FAIL scoreboard_ack: got 0x%02h, required 0x%02h", tx_data, sb_exp);
        end
      end
      tx_ready = 1'b0;
      tx_busy  = 5;
    end else if (!tx_ready) begin
      tx_ready = 1'b1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int i = 0;
    while (busy && i < budget) begin
      @(negedge clk);
      i++;
    end
    n_checks++;
    if (busy) begin
      n_fail++;
      $display("FAIL %s_idle_timeout: busy=%0b after %0d clks, required 0", name, busy, budget);
    end
  endtask

  task automatic check_q_empty(input string name);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_ack_missing: %0d acks outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({tx_start, tx_data, csoc_clk, csoc_rstn, csoc_test_se, csoc_test_tm, busy, overrun} !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got {txs,txd,clk,rstn,se,tm,busy,ovr}=%b_%h_%b%b%b%b%b%b, required all 0",
               tx_start, tx_data, csoc_clk, csoc_rstn, csoc_test_se, csoc_test_tm, busy, overrun);
    end
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || csoc_clk !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: busy=%b csoc_clk=%b, required 0 0", busy, csoc_clk);
    end
  endtask

  task automatic test_zero_pulse;
    edge_cnt = 0;
    exp_q.push_back(8'h6B);
    send_byte(8'h65); send_byte(8'h00); send_byte(8'h00);
    wait_idle("zero_pulse", 200);
    n_checks++;
    if (edge_cnt != 0 || csoc_rstn !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_pulse: edges=%0d csoc_rstn=%b, required 0 edges and csoc_rstn=1", edge_cnt, csoc_rstn);
    end
    check_q_empty("zero_pulse");
  endtask

  task automatic test_pulse_train;
    edge_cnt = 0; gap_err = 0; clk_idle_err = 0;
    exp_q.push_back(8'h6B);
    send_byte(8'h65); send_byte(8'h00); send_byte(8'h08);
    wait_idle("pulse_train", 500);
    n_checks++;
    if (edge_cnt != 8) begin
      n_fail++;
      $display("FAIL pulse_train_count: got %0d edges, required 8", edge_cnt);
    end
    n_checks++;
    if (gap_err != 0 || clk_idle_err != 0) begin
      n_fail++;
      $display("FAIL pulse_train_timing: gap errors=%0d clk-while-idle=%0d, required 0 0", gap_err, clk_idle_err);
    end
    check_q_empty("pulse_train");
  endtask

  task automatic test_mode_and_reset;
    exp_q.push_back(8'h6B);
    send_byte(8'h74); send_byte(8'h03);
    wait_idle("mode3", 200);
    n_checks++;
    if (csoc_test_tm !== 1'b1 || csoc_test_se !== 1'b1) begin
      n_fail++;
      $display("FAIL mode3: tm=%b se=%b, required 1 1", csoc_test_tm, csoc_test_se);
    end
    last_low = 0;
    exp_q.push_back(8'h6B);
    send_byte(8'h72);
    wait_idle("rst_cmd", 200);
    n_checks++;
    if (last_low != RST_CYCLES || csoc_rstn !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pulse: low for %0d clks, csoc_rstn=%b, required %0d and 1", last_low, csoc_rstn, RST_CYCLES);
    end
    exp_q.push_back(8'h6B);
    send_byte(8'h74); send_byte(8'hFE);
    wait_idle("mode_fe", 200);
    n_checks++;
    if (csoc_test_tm !== 1'b0 || csoc_test_se !== 1'b1) begin
      n_fail++;
      $display("FAIL mode_fe: tm=%b se=%b, required 0 1", csoc_test_tm, csoc_test_se);
    end
    check_q_empty("mode_and_reset");
  endtask

  task automatic test_unknown_and_overrun;
    exp_q.push_back(8'h3F);
    send_byte(8'h78);
    wait_idle("unknown", 200);
    n_checks++;
    if (overrun !== 1'b0 || csoc_rstn !== 1'b1 || csoc_test_se !== 1'b1 || csoc_test_tm !== 1'b0) begin
      n_fail++;
      $display("FAIL unknown_pins: ovr=%b rstn=%b se=%b tm=%b, required 0 1 1 0",
               overrun, csoc_rstn, csoc_test_se, csoc_test_tm);
    end
    edge_cnt = 0; gap_err = 0;
    exp_q.push_back(8'h6B);
    send_byte(8'h65); send_byte(8'h01); send_byte(8'h00);
    repeat (20) @(negedge clk);
    send_byte(8'h7A);
    n_checks++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_flag: got %b, required 1", overrun);
    end
    wait_idle("run256", 5000);
    n_checks++;
    if (edge_cnt != 256 || gap_err != 0) begin
      n_fail++;
      $display("FAIL run256_count: edges=%0d gap errors=%0d, required 256 0", edge_cnt, gap_err);
    end
    check_q_empty("unknown_and_overrun");
  endtask

  task automatic test_ack_backpressure;
    int start0;
    int viol = 0;
    tx_hold = 1'b1;
    @(negedge clk);
    start0 = tx_start_cnt;
    exp_q.push_back(8'h3F);
    send_byte(8'h51);
    repeat (50) begin
      @(negedge clk);
      if (tx_start) viol++;
    end
    n_checks++;
    if (viol != 0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ack_hold: tx_start high %0d clks, busy=%b, required 0 clks and busy=1", viol, busy);
    end
    tx_hold = 1'b0;
    wait_idle("ack_hold", 200);
    n_checks++;
    if (tx_start_cnt - start0 != 1) begin
      n_fail++;
      $display("FAIL ack_single: %0d tx_start pulses, required 1", tx_start_cnt - start0);
    end
    check_q_empty("ack_backpressure");
  endtask

  task automatic test_reset_mid_run;
    edge_cnt = 0;
    send_byte(8'h65); send_byte(8'h00); send_byte(8'h20);
    repeat (30) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || edge_cnt == 0) begin
      n_fail++;
      $display("FAIL mid_run_active: busy=%b edges=%0d, required busy=1 and edges>0", busy, edge_cnt);
    end
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({tx_start, tx_data, csoc_clk, csoc_rstn, csoc_test_se, csoc_test_tm, busy, overrun} !== 14'h0) begin
      n_fail++;
      $display("FAIL mid_run_reset: got {txs,txd,clk,rstn,se,tm,busy,ovr}=%b_%h_%b%b%b%b%b%b, required all 0",
               tx_start, tx_data, csoc_clk, csoc_rstn, csoc_test_se, csoc_test_tm, busy, overrun);
    end
    @(negedge clk);
    rstn = 1'b1;
    edge_cnt = 0;
    repeat (20) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || edge_cnt != 0 || tx_start !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_quiet: busy=%b edges=%0d tx_start=%b, required 0 0 0", busy, edge_cnt, tx_start);
    end
    exp_q.push_back(8'h3F);
    send_byte(8'h00);
    wait_idle("post_reset_cmd", 200);
    check_q_empty("reset_mid_run");
  endtask

`ifdef CSOC_CMD_TIMEOUT_EN
  task automatic test_timeout;
    edge_cnt = 0;
    exp_q.push_back(8'h21);
    send_byte(8'h65); send_byte(8'h00);
    wait_idle("timeout", TIMEOUT_CYCLES + 100);
    n_checks++;
    if (busy !== 1'b0 || edge_cnt != 0 || csoc_rstn !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_abort: busy=%b edges=%0d csoc_rstn=%b, required 0 0 0", busy, edge_cnt, csoc_rstn);
    end
    check_q_empty("timeout");
  endtask
`endif

  initial begin
    test_reset();
    test_zero_pulse();
    test_pulse_train();
    test_mode_and_reset();
    test_unknown_and_overrun();
    test_ack_backpressure();
    test_reset_mid_run();
`ifdef CSOC_CMD_TIMEOUT_EN
    test_timeout();
`endif
    repeat (10) @(negedge clk);
    check_q_empty("final");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
